// File: rtl/cgra_pkg.sv
// cgra_pkg: shared CGRA column constants and the RC memory responder state type.
package cgra_pkg;
   localparam int N_ROWS = 4;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} rc_rsp_state_t;
endpackage

// File: rtl/rc_req_prio_enc.sv
// rc_req_prio_enc: index of the lowest set request bit, plus an any-set flag.
module rc_req_prio_enc #(
   parameter int N_RC = 4,
   parameter int IW   = (N_RC > 1) ? $clog2(N_RC) : 1
) (
   input  logic [N_RC-1:0] i_req,
   output logic [IW-1:0]   o_idx,
   output logic            o_valid
);
   always_comb begin
      o_idx   = '0;
      o_valid = |i_req;
      for (int i = N_RC - 1; i >= 0; i--)
         if (i_req[i]) o_idx = IW'(i);
   end
endmodule

// File: rtl/rc_mem_responder.sv
// rc_mem_responder: serialises a column's RC load/store batch onto one OBI master port.
// Define CGRA_RSP_ERR_EN to add bus_err_i (zeroes load data) and a sticky err_o.
module rc_mem_responder
   import cgra_pkg::*;
#(
   parameter int N_RC     = N_ROWS,
   parameter int DP_WIDTH = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [N_RC-1:0]          rc_req_i,
   input  logic [N_RC-1:0]          rc_wen_i,
   input  logic [N_RC-1:0]          rc_ind_i,
   input  logic [N_RC*DP_WIDTH-1:0] rc_add_i,
   input  logic [N_RC*DP_WIDTH-1:0] rc_wdata_i,
   input  logic [DP_WIDTH-1:0]      base_ptr_i,
   output logic [N_RC*DP_WIDTH-1:0] rc_rdata_o,
   output logic [N_RC-1:0]          rc_rvalid_o,
   output logic                     col_stall_o,
   output logic                     bus_req_o,
   input  logic                     bus_gnt_i,
   output logic [DP_WIDTH-1:0]      bus_addr_o,
   output logic                     bus_we_o,
   output logic [DP_WIDTH/8-1:0]    bus_be_o,
   output logic [DP_WIDTH-1:0]      bus_wdata_o,
   input  logic                     bus_rvalid_i,
   input  logic [DP_WIDTH-1:0]      bus_rdata_i
`ifdef CGRA_RSP_ERR_EN
   ,
   input  logic                     bus_err_i,
   output logic                     err_o
`endif
);
   localparam int IW = (N_RC > 1) ? $clog2(N_RC) : 1;

   rc_rsp_state_t            r_state;
   logic [N_RC-1:0]          r_pend;
   logic [N_RC-1:0]          r_rvalid;
   logic [N_RC*DP_WIDTH-1:0] r_rdata;
   logic [IW-1:0]            r_k;
   logic                     r_we;
   logic [IW-1:0]            w_k;
   logic                     w_valid;
   logic                     w_issue;
   logic                     w_resp;
   logic                     w_err;
   logic [N_RC-1:0]          w_done_oh;
   logic [N_RC-1:0]          w_left;
   logic [DP_WIDTH-1:0]      w_add;

   rc_req_prio_enc #(.N_RC(N_RC), .IW(IW)) u_enc (
      .i_req   (r_pend),
      .o_idx   (w_k),
      .o_valid (w_valid)
   );

`ifdef CGRA_RSP_ERR_EN
   logic r_err;
   assign w_err = bus_err_i;
   assign err_o = r_err;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) r_err <= 1'b0;
      else if (w_resp && bus_err_i) r_err <= 1'b1;
`else
   assign w_err = 1'b0;
`endif

   assign w_issue     = r_state == ISSUE;
   assign w_resp      = r_state == WAIT && bus_rvalid_i;
   assign w_done_oh   = N_RC'(1) << r_k;
   assign w_left      = r_pend & ~w_done_oh;
   assign w_add       = rc_add_i[w_k*DP_WIDTH +: DP_WIDTH];
   // Request fields stay stable while ungranted because stalled RCs hold their inputs.
   assign bus_req_o   = w_issue & w_valid;
   assign bus_addr_o  = w_issue ? (rc_ind_i[w_k] ? base_ptr_i + w_add : w_add) : '0;
   assign bus_we_o    = w_issue & rc_wen_i[w_k];
   assign bus_wdata_o = w_issue ? rc_wdata_i[w_k*DP_WIDTH +: DP_WIDTH] : '0;
   assign bus_be_o    = '1;
   assign rc_rdata_o  = r_rdata;
   assign rc_rvalid_o = r_rvalid;
   assign col_stall_o = rst_ni & ((r_state == IDLE) ? |rc_req_i : (w_issue || r_state == WAIT));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= IDLE;
         r_pend   <= '0;
         r_rvalid <= '0;
         r_rdata  <= '0;
         r_k      <= '0;
         r_we     <= 1'b0;
      end else begin
         r_rvalid <= w_resp ? w_done_oh : '0;
         case (r_state)
            IDLE: if (|rc_req_i) begin
               r_pend  <= rc_req_i;
               r_state <= ISSUE;
            end
            ISSUE: if (bus_gnt_i) begin
               r_k     <= w_k;
               r_we    <= rc_wen_i[w_k];
               r_state <= WAIT;
            end
            WAIT: if (bus_rvalid_i) begin
               if (!r_we) r_rdata[r_k*DP_WIDTH +: DP_WIDTH] <= w_err ? '0 : bus_rdata_i;
               r_pend  <= w_left;
               r_state <= |w_left ? ISSUE : DONE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rc_mem_responder.sv
// tb_rc_mem_responder: scoreboarded bench driving RC batches and playing the OBI slave.
module tb_rc_mem_responder;
   typedef struct {int idx; logic [31:0] data;} exp_t;

   logic         clk = 1'b0;
   logic         rst_ni = 1'b0;
   logic [3:0]   rc_req_i = '0, rc_wen_i = '0, rc_ind_i = '0;
   logic [127:0] rc_add_i = '0, rc_wdata_i = '0;
   logic [31:0]  base_ptr_i = '0;
   logic [127:0] rc_rdata_o;
   logic [3:0]   rc_rvalid_o;
   logic         col_stall_o, bus_req_o, bus_we_o;
   logic         bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0, bus_err = 1'b0;
   logic [31:0]  bus_addr_o, bus_wdata_o, bus_rdata_i = '0;
   logic [3:0]   bus_be_o;
`ifdef CGRA_RSP_ERR_EN
   logic         err_o;
`endif

   int           n_chk = 0, n_pass = 0;
   exp_t         q[$];
   exp_t         e;
   logic [31:0]  shadow [4];
   logic [31:0]  t_add [4], t_wd [4], t_rd [4];

   rc_mem_responder dut (
      .clk_i(clk), .rst_ni(rst_ni), .rc_req_i(rc_req_i), .rc_wen_i(rc_wen_i),
      .rc_ind_i(rc_ind_i), .rc_add_i(rc_add_i), .rc_wdata_i(rc_wdata_i),
      .base_ptr_i(base_ptr_i), .rc_rdata_o(rc_rdata_o), .rc_rvalid_o(rc_rvalid_o),
      .col_stall_o(col_stall_o), .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
      .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
      .bus_wdata_o(bus_wdata_o), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
`ifdef CGRA_RSP_ERR_EN
      , .bus_err_i(bus_err), .err_o(err_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Scoreboard consumer: every rc_rvalid_o pulse must match the oldest expectation.
   always @(negedge clk)
      if (rst_ni && rc_rvalid_o != 0) begin
         if (q.size() == 0) chk("unexpected_rvalid", {124'b0, rc_rvalid_o}, 128'b0);
         else begin
            e = q.pop_front();
            chk("sb_rvalid", {124'b0, rc_rvalid_o}, 128'b1 << e.idx);
            chk("sb_rdata", {96'b0, rc_rdata_o[e.idx*32 +: 32]}, {96'b0, e.data});
         end
      end

   task automatic serve(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int gdly, input logic first, input logic last,
                        input logic err);
      int n = 0;
      while (!bus_req_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("issue_latency", n, first ? 1 : 0);
      chk("bus_req", bus_req_o, 1);
      chk("bus_addr", bus_addr_o, addr);
      chk("bus_we", bus_we_o, we);
      if (we) chk("bus_wdata", bus_wdata_o, wd);
      chk("bus_be", bus_be_o, 4'hF);
      chk("stall_issue", col_stall_o, 1);
      repeat (gdly) begin
         @(negedge clk);
         chk("bp_req", bus_req_o, 1);
         chk("bp_addr", bus_addr_o, addr);
         chk("bp_we", bus_we_o, we);
         chk("bp_wdata", bus_wdata_o, rc_wdata_i[k*32 +: 32]);
         chk("bp_no_rvalid", rc_rvalid_o, 0);
      end
      bus_gnt_i = 1'b1;
      @(negedge clk);
      bus_gnt_i = 1'b0;
      chk("wait_req", bus_req_o, 0);
      chk("wait_stall", col_stall_o, 1);
      bus_rvalid_i = 1'b1;
      bus_rdata_i = rd;
      bus_err = err;
      @(negedge clk);
      bus_rvalid_i = 1'b0;
      bus_rdata_i = '0;
      bus_err = 1'b0;
      chk("rvalid_pulse", rc_rvalid_o, 4'b1 << k);
      chk("stall_after_rsp", col_stall_o, !last);
   endtask

   task automatic run_batch(input logic [3:0] req, input logic [3:0] wen, input logic [3:0] ind,
                            input logic [31:0] base, input int gdly, input logic [3:0] errs);
      logic first = 1'b1;
      rc_req_i = req;
      rc_wen_i = wen;
      rc_ind_i = ind;
      base_ptr_i = base;
      for (int k = 0; k < 4; k++) begin
         rc_add_i[k*32 +: 32] = t_add[k];
         rc_wdata_i[k*32 +: 32] = t_wd[k];
      end
      #1 chk("stall_idle", col_stall_o, 1);
      for (int k = 0; k < 4; k++)
         if (req[k]) begin
            if (!wen[k]) shadow[k] = errs[k] ? 32'h0 : t_rd[k];
            q.push_back('{k, shadow[k]});
         end
      for (int k = 0; k < 4; k++)
         if (req[k]) begin
            serve(k, wen[k], ind[k] ? base + t_add[k] : t_add[k], t_wd[k], t_rd[k], gdly,
                  first, (req >> (k + 1)) == 0, errs[k]);
            first = 1'b0;
         end
      rc_req_i = '0;
      @(negedge clk);
      chk("idle_stall", col_stall_o, 0);
   endtask

   initial begin
      for (int k = 0; k < 4; k++) shadow[k] = '0;
      repeat (3) @(negedge clk);
      chk("rst_bus_req", bus_req_o, 0);
      chk("rst_bus_be", bus_be_o, 4'hF);
      chk("rst_stall", col_stall_o, 0);
      chk("rst_rvalid", rc_rvalid_o, 0);
      chk("rst_rdata", rc_rdata_o, 0);
      chk("rst_addr", bus_addr_o, 0);
      rst_ni = 1'b1;
      @(negedge clk);
      // single load on RC2
      t_add = '{32'h0, 32'h0, 32'h100, 32'h0};
      t_wd = '{32'h0, 32'h0, 32'h0, 32'h0};
      t_rd = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
      run_batch(4'b0100, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000);
      // RC0 store and RC3 load in one batch
      t_add = '{32'h40, 32'h0, 32'h0, 32'h80};
      t_wd = '{32'h11223344, 32'h0, 32'h0, 32'h55667788};
      t_rd = '{32'hBAD0BAD0, 32'h0, 32'h0, 32'hCAFEF00D};
      run_batch(4'b1001, 4'b0001, 4'b0000, 32'h0, 0, 4'b0000);
      // indirect address wrapping past 2^32
      t_add = '{32'h0, 32'h20, 32'h0, 32'h0};
      t_rd = '{32'h0, 32'h0BADF00D, 32'h0, 32'h0};
      run_batch(4'b0010, 4'b0000, 4'b0010, 32'hFFFFFFF0, 0, 4'b0000);
      // grant held off for five cycles
      t_add = '{32'h200, 32'h0, 32'h300, 32'h0};
      t_wd = '{32'h0, 32'h0, 32'hA5A5A5A5, 32'h0};
      t_rd = '{32'h13572468, 32'h0, 32'hFFFF0000, 32'h0};
      run_batch(4'b0101, 4'b0100, 4'b0100, 32'h1000, 5, 4'b0000);
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 4; k++) begin
            t_add[k] = $urandom;
            t_wd[k] = $urandom;
            t_rd[k] = $urandom;
         end
         run_batch(4'($urandom_range(1, 15)), 4'($urandom), 4'($urandom), $urandom,
                   $urandom_range(0, 2), 4'b0000);
      end
`ifdef CGRA_RSP_ERR_EN
      chk("err_clear", err_o, 0);
      t_add = '{32'h0, 32'h0, 32'h0, 32'h400};
      t_rd = '{32'h0, 32'h0, 32'h0, 32'h77777777};
      run_batch(4'b1000, 4'b0000, 4'b0000, 32'h0, 0, 4'b1000);
      chk("err_set", err_o, 1);
      run_batch(4'b1000, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000);
      chk("err_sticky", err_o, 1);
`endif
      chk("sb_drained", q.size(), 0);
      // reset while a load waits for its response
      t_add = '{32'h0, 32'h500, 32'h0, 32'h0};
      rc_req_i = 4'b0010;
      rc_wen_i = '0;
      rc_ind_i = '0;
      rc_add_i[32 +: 32] = 32'h500;
      @(negedge clk);
      chk("mid_req", bus_req_o, 1);
      bus_gnt_i = 1'b1;
      @(negedge clk);
      bus_gnt_i = 1'b0;
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_req", bus_req_o, 0);
      chk("mid_rst_stall", col_stall_o, 0);
      chk("mid_rst_rvalid", rc_rvalid_o, 0);
      chk("mid_rst_rdata", rc_rdata_o, 0);
      chk("mid_rst_addr", bus_addr_o, 0);
      @(negedge clk);
      rc_req_i = '0;
      rst_ni = 1'b1;
      bus_rvalid_i = 1'b1;
      bus_rdata_i = 32'h12345678;
      @(negedge clk);
      bus_rvalid_i = 1'b0;
      chk("late_rvalid", rc_rvalid_o, 0);
      @(negedge clk);
      chk("late_rvalid2", rc_rvalid_o, 0);
      chk("late_rdata", rc_rdata_o, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
